// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, types and helpers for the FIFO controller
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEPTH          = 2**DEF_ADDR_WIDTH;
  localparam int CNT_W          = DEF_ADDR_WIDTH + 1;

  // Encoding of {push, pop} for a cycle; drives the occupancy update.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Number of RAM entries for a given address width.
  function automatic int depth_of(input int aw);
    return 2**aw;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - producer/consumer stream bundle; FIFO_CTRL_PEEK_EN adds next-word peek
interface fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
`ifdef FIFO_CTRL_PEEK_EN
  logic [DATA_WIDTH-1:0] m_data_next;
  logic                  m_valid_next;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_data_next, m_valid_next
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_data_next, m_valid_next
  );
`else
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
`endif

endinterface

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping RAM pointer with increment and synchronous clear
module fifo_ptr #(
  parameter int WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  // Clear has priority over increment; wrap comes from natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - ready/valid FIFO controller for an external dual-port RAM; option FIFO_CTRL_PEEK_EN
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AFULL_LVL  = 2**ADDR_WIDTH - 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  fifo_ctrl_if.slave            bus,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_afull,
  output logic [ADDR_WIDTH:0]   o_hwm,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr_1,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data_1,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr_2,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data_2
);

  localparam int            CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(depth_of(ADDR_WIDTH));
  localparam logic [CW-1:0] L_AFULL = CW'(AFULL_LVL);

  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_hwm;
  logic [CW-1:0]         w_count_nxt;
  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic [ADDR_WIDTH-1:0] w_rd_ptr;
  logic                  w_s_ready;
  logic                  w_m_valid;
  logic                  w_push;
  logic                  w_pop;
  fifo_op_e              w_op;

  // Handshakes depend only on registered state plus flush, so there is no
  // combinational path from m_ready to s_ready or from s_valid to m_valid.
  assign w_s_ready = (r_count != L_DEPTH) & ~i_flush;
  assign w_m_valid = (r_count != '0);
  assign w_push    = bus.s_valid & w_s_ready;
  assign w_pop     = w_m_valid & bus.m_ready;

  fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (w_push),
    .o_ptr   (w_wr_ptr)
  );

  fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_inc   (w_pop),
    .o_ptr   (w_rd_ptr)
  );

  // Next occupancy from this cycle's push/pop combination.
  always_comb begin
    w_op        = fifo_op_e'({w_push, w_pop});
    w_count_nxt = r_count;
    case (w_op)
      OP_PUSH: w_count_nxt = r_count + CW'(1);
      OP_POP:  w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Occupancy register; flush drops everything including a concurrent pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // High-water mark tracks the peak occupancy since reset or flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hwm <= '0;
    end else if (i_flush) begin
      r_hwm <= '0;
    end else if (w_count_nxt > r_hwm) begin
      r_hwm <= w_count_nxt;
    end
  end

  assign bus.s_ready     = w_s_ready;
  assign bus.m_valid     = w_m_valid;
  assign bus.m_data      = i_ram_rd_data_1;
  assign o_count         = r_count;
  assign o_afull         = (r_count >= L_AFULL);
  assign o_hwm           = r_hwm;
  assign o_ram_we        = w_push;
  assign o_ram_wr_addr   = w_wr_ptr;
  assign o_ram_wr_data   = bus.s_data;
  assign o_ram_rd_addr_1 = w_rd_ptr;

`ifdef FIFO_CTRL_PEEK_EN
  assign o_ram_rd_addr_2  = w_rd_ptr + ADDR_WIDTH'(1);
  assign bus.m_data_next  = i_ram_rd_data_2;
  assign bus.m_valid_next = (r_count >= CW'(2));
`else
  logic w_unused_rd_data_2;

  assign o_ram_rd_addr_2    = '0;
  assign w_unused_rd_data_2 = ^i_ram_rd_data_2;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - scoreboard bench for fifo_ctrl with a behavioural RAM
module tb_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   count;
  logic          afull;
  logic [AW:0]   hwm;
  logic          ram_we;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr_1;
  logic [DW-1:0] ram_rd_data_1;
  logic [AW-1:0] ram_rd_addr_2;
  logic [DW-1:0] ram_rd_data_2;
  logic [DW-1:0] mem [4];

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] q [$];

  always #5 clk = ~clk;

  fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .AFULL_LVL  (3)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_flush         (flush),
    .bus             (bus),
    .o_count         (count),
    .o_afull         (afull),
    .o_hwm           (hwm),
    .o_ram_we        (ram_we),
    .o_ram_wr_addr   (ram_wr_addr),
    .o_ram_wr_data   (ram_wr_data),
    .o_ram_rd_addr_1 (ram_rd_addr_1),
    .i_ram_rd_data_1 (ram_rd_data_1),
    .o_ram_rd_addr_2 (ram_rd_addr_2),
    .i_ram_rd_data_2 (ram_rd_data_2)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
  end
  assign ram_rd_data_1 = mem[ram_rd_addr_1];
  assign ram_rd_data_2 = mem[ram_rd_addr_2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must deliver the oldest queued word.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got 0x%0h expected no pop", bus.m_data);
        end else begin
          e = q.pop_front();
          chk("pop_data", int'(bus.m_data), int'(e));
        end
      end
    end
  end

  // One clock of stimulus; accepted pushes become expected pops.
  task automatic cyc(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
    bus.s_valid = sv;
    bus.s_data  = sd;
    bus.m_ready = mr;
    flush       = fl;
    @(negedge clk);
    if (sv && bus.s_ready) q.push_back(sd);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    #12;
    chk("rst_s_ready", int'(bus.s_ready), 1);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_afull", int'(afull), 0);
    chk("rst_hwm", int'(hwm), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single word round trip
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    chk("one_m_valid", int'(bus.m_valid), 1);
    chk("one_m_data", int'(bus.m_data), 'hA1);
    chk("one_count", int'(count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("one_pop_count", int'(count), 0);
    chk("one_pop_m_valid", int'(bus.m_valid), 0);

    // fill to full, blocked fifth push, drain in order
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 2) chk("afull_at_2", int'(afull), 0);
      if (i == 3) chk("afull_at_3", int'(afull), 1);
    end
    chk("full_count", int'(count), 4);
    chk("full_s_ready", int'(bus.s_ready), 0);
    chk("full_afull", int'(afull), 1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h05;
    #1;
    chk("full_ram_we", int'(ram_we), 0);
    cyc(1'b1, 8'h05, 1'b0, 1'b0);
    chk("full_count_hold", int'(count), 4);
    chk("full_hwm", int'(hwm), 4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_count", int'(count), 0);
    chk("drain_hwm", int'(hwm), 4);

    // flush, then steady push+pop across pointer wrap
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_hwm", int'(hwm), 0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
      chk("steady_count", int'(count), 2);
    end
    chk("wrap_wr_addr", int'(ram_wr_addr), 0);
    chk("wrap_rd_addr", int'(ram_rd_addr_1), 2);
    chk("steady_hwm", int'(hwm), 2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_drain_count", int'(count), 0);

    // high-water mark and flush behaviour
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("hwm_3", int'(hwm), 3);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush2_count", int'(count), 0);
    chk("flush2_hwm", int'(hwm), 0);
    chk("flush2_m_valid", int'(bus.m_valid), 0);
    bus.s_valid = 1'b1;
    flush       = 1'b1;
    #1;
    chk("flush_push_s_ready", int'(bus.s_ready), 0);
    chk("flush_push_ram_we", int'(ram_we), 0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    chk("flush_push_count", int'(count), 0);
    chk("flush_push_m_valid", int'(bus.m_valid), 0);

    // asynchronous reset mid-stream
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
    cyc(1'b1, 8'h62, 1'b0, 1'b0);
    chk("pre_rst_count", int'(count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", int'(bus.m_valid), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_s_ready", int'(bus.s_ready), 1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // peek at the word behind the head
    cyc(1'b1, 8'h10, 1'b0, 1'b0);
    cyc(1'b1, 8'h20, 1'b0, 1'b0);
    chk("peek_m_data", int'(bus.m_data), 'h10);
`ifdef FIFO_CTRL_PEEK_EN
    chk("peek_next_data", int'(bus.m_data_next), 'h20);
    chk("peek_next_valid", int'(bus.m_valid_next), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("peek_next_valid_after_pop", int'(bus.m_valid_next), 0);
`else
    chk("no_peek_rd_addr_2", int'(ram_rd_addr_2), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
`endif
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("end_count", int'(count), 0);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
